keypad_uart_tx: RTL and testbench

Drain-side consumer for the keypad key-code FIFO. Pops one key code at a time from the FIFO read port and serialises it as an 8N1 UART frame on a single TX line, LSB first. It sits between the keypad FIFO and the board UART pin, and reports a running count of frames sent.

---
 rtl/keypad_uart_tx.sv | 135 +++++++++++++
 tb/tb_keypad_uart_tx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_uart_tx.sv
// Keypad FIFO drain: pops one key code per frame and shifts it out as UART (LSB first).
// Define KEYPAD_UART_TX_PARITY_EN for 8E1 framing (even parity bit between data and stop).
module keypad_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_WIDTH    = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  tx_en_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           frame_cnt_o
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] BAUD_TC  = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]     LAST_BIT = IDX_W'(DATA_WIDTH - 1);

`ifdef KEYPAD_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;
`endif

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    tx_q, tx_d;
    logic [15:0]             frame_cnt_q;
    logic                    baud_tc;
`ifdef KEYPAD_UART_TX_PARITY_EN
    logic                    par_q, par_d;
`endif

    assign baud_tc      = (cnt_q == BAUD_TC);
    // Reset gates the strobe so a held reset never pops the FIFO.
    assign fifo_rd_en_o = (state_q == IDLE) & tx_en_i & ~fifo_empty_i & ~rst_i;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == STOP) & baud_tc;
    assign tx_o         = tx_q;
    assign frame_cnt_o  = frame_cnt_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
`ifdef KEYPAD_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (fifo_rd_en_o) state_d = FETCH;
            end
            FETCH: begin
                shift_d = fifo_rd_data_i;
                idx_d   = '0;
                cnt_d   = '0;
`ifdef KEYPAD_UART_TX_PARITY_EN
                par_d   = ^fifo_rd_data_i;
`endif
                state_d = START;
            end
            START: begin
                if (baud_tc) state_d = DATA;
            end
            DATA: begin
                if (baud_tc) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == LAST_BIT) begin
`ifdef KEYPAD_UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef KEYPAD_UART_TX_PARITY_EN
            PARITY: begin
                if (baud_tc) state_d = STOP;
            end
`endif
            STOP: begin
                if (baud_tc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && state_q != FETCH)
            cnt_d = baud_tc ? '0 : cnt_q + CNT_WIDTH'(1);

        // Line level is registered from the next state so tx_o is glitch-free.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef KEYPAD_UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            tx_q        <= 1'b1;
            frame_cnt_q <= '0;
`ifdef KEYPAD_UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
`ifdef KEYPAD_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
            if (done_o) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_keypad_uart_tx.sv
// Bench for keypad_uart_tx: FIFO model plus a slot-based line model of the UART frame.
module tb_keypad_uart_tx;
    localparam int CPB = 4;
`ifdef KEYPAD_UART_TX_PARITY_EN
    localparam int NSLOT = 11;
`else
    localparam int NSLOT = 10;
`endif
    localparam int FRAME = 2 + NSLOT * CPB;

    logic        clk = 1'b0;
    logic        rst_i, tx_en_i, fifo_empty_i, fifo_rd_en_o;
    logic        tx_o, busy_o, done_o;
    logic [7:0]  fifo_rd_data_i = 8'h00;
    logic [15:0] frame_cnt_o;

    int n_cmp = 0, n_fail = 0;
    int exp_cnt = 0, exp_reads = 0;
    logic [7:0] mem [256];
    int head = 0, tail = 0, rd_cnt = 0;
    logic [7:0] v;
    logic [7:0] rb [6];

    always #5 clk = ~clk;

    keypad_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .CNT_WIDTH(10)) dut (
        .clk_i(clk), .rst_i(rst_i), .tx_en_i(tx_en_i), .fifo_empty_i(fifo_empty_i),
        .fifo_rd_en_o(fifo_rd_en_o), .fifo_rd_data_i(fifo_rd_data_i), .tx_o(tx_o),
        .busy_o(busy_o), .done_o(done_o), .frame_cnt_o(frame_cnt_o)
    );

    // FIFO: data appears the cycle after the strobe; garbage otherwise.
    assign fifo_empty_i = (head == tail);
    always @(posedge clk) begin
        if (fifo_rd_en_o && head != tail) begin
            fifo_rd_data_i <= mem[head[7:0]];
            head <= head + 1;
        end else begin
            fifo_rd_data_i <= 8'($urandom);
        end
        if (fifo_rd_en_o) rd_cnt <= rd_cnt + 1;
    end

    // Expected line level c cycles after the read strobe, by bit slot.
    function automatic logic exp_tx(input logic [7:0] b, input int c);
        int slot;
        if (c < 2) return 1'b1;
        slot = (c - 2) / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (NSLOT == 11 && slot == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic chk1(input string tag, input int cyc, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input int cyc, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[tail[7:0]] = b;
        tail = tail + 1;
    endtask

    task automatic wait_rd(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            #1;
            if (fifo_rd_en_o === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        chk1(tag, 0, seen, 1'b1);
    endtask

    // Called in the strobe cycle; returns in the following IDLE cycle.
    task automatic check_frame(input logic [7:0] b, input logic nxt, input int drop_at);
        chk1("start_tx", 0, tx_o, 1'b1);
        chk1("start_busy", 0, busy_o, 1'b0);
        exp_reads++;
        for (int c = 1; c < FRAME; c++) begin
            step();
            chk1("tx", c, tx_o, exp_tx(b, c));
            chk1("busy", c, busy_o, 1'b1);
            chk1("done", c, done_o, c == FRAME - 1);
            chk1("rd_mid", c, fifo_rd_en_o, 1'b0);
            chk16("cnt_hold", c, frame_cnt_o, 16'(exp_cnt));
            if (c == drop_at) tx_en_i = 1'b0;
        end
        step();
        exp_cnt = (exp_cnt + 1) & 16'hFFFF;
        chk16("cnt", FRAME, frame_cnt_o, 16'(exp_cnt));
        chk1("end_done", FRAME, done_o, 1'b0);
        chk1("end_busy", FRAME, busy_o, 1'b0);
        chk1("end_tx", FRAME, tx_o, 1'b1);
        chk1("next_rd", FRAME, fifo_rd_en_o, nxt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1;
        tx_en_i = 1'b1;
        push(8'h35);
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("rst_tx", i, tx_o, 1'b1);
            chk1("rst_rd", i, fifo_rd_en_o, 1'b0);
            chk1("rst_busy", i, busy_o, 1'b0);
            chk1("rst_done", i, done_o, 1'b0);
            chk16("rst_cnt", i, frame_cnt_o, 16'h0000);
        end
        rst_i = 1'b0;
        wait_rd("rd_35");
        check_frame(8'h35, 1'b0, 0);

        push(8'h31);
        push(8'h32);
        wait_rd("rd_31");
        check_frame(8'h31, 1'b1, 0);
        check_frame(8'h32, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk1("empty_rd", i, fifo_rd_en_o, 1'b0);
        end

        push(8'hA5);
        wait_rd("rd_a5");
        v = 8'($urandom);
        push(v);
        check_frame(8'hA5, 1'b0, 2 + 4 * CPB);
        for (int i = 0; i < 20; i++) begin
            step();
            chk1("txen_off_rd", i, fifo_rd_en_o, 1'b0);
        end
        tx_en_i = 1'b1;
        wait_rd("rd_resume");
        check_frame(v, 1'b0, 0);

        push(8'hFF);
        push(8'h3C);
        wait_rd("rd_ff");
        exp_reads++;
        for (int c = 1; c <= 2 + 4 * CPB - 1; c++) step();
        chk1("ff_bit3", 0, tx_o, exp_tx(8'hFF, 2 + 4 * CPB - 1));
        rst_i = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk1("mrst_tx", i, tx_o, 1'b1);
            chk1("mrst_busy", i, busy_o, 1'b0);
            chk1("mrst_rd", i, fifo_rd_en_o, 1'b0);
            chk16("mrst_cnt", i, frame_cnt_o, 16'h0000);
        end
        rst_i = 1'b0;
        wait_rd("rd_3c");
        check_frame(8'h3C, 1'b0, 0);

        push(8'h07);
        push(8'h03);
        for (int i = 0; i < 6; i++) begin
            rb[i] = 8'($urandom);
            push(rb[i]);
        end
        wait_rd("rd_chain");
        check_frame(8'h07, 1'b1, 0);
        check_frame(8'h03, 1'b1, 0);
        for (int i = 0; i < 6; i++) check_frame(rb[i], i < 5, 0);

        step();
        chk16("reads", 0, 16'(rd_cnt), 16'(exp_reads));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
